// File: rtl/tone_pkg.sv
// Shared definitions for the tone period meter: note table and FSM encoding.
package tone_pkg;

    localparam int N_NOTES = 8;
    localparam int NOTE_W  = 17;

    // Reference periods in clk cycles at 25 MHz: A4 B4 C5 D5 E5 F5 G5 A5
    localparam logic [NOTE_W-1:0] NOTE_PERIOD [N_NOTES] = '{
        17'd56818, 17'd50619, 17'd47778, 17'd42565,
        17'd37922, 17'd35793, 17'd31888, 17'd28409
    };

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/note_classifier.sv
// Combinational match of a measured period against the note table.
module note_classifier
    import tone_pkg::*;
#(
    parameter int CNT_W = 17,
    parameter int TOL   = 256
) (
    input  logic [CNT_W-1:0] period_in,
    output logic             note_hit,
    output logic [2:0]       note_idx
);

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        note_hit = 1'b0;
        note_idx = 3'd0;
        for (int i = N_NOTES - 1; i >= 0; i--) begin
            if (abs_diff({1'b0, period_in}, (CNT_W+1)'(NOTE_PERIOD[i])) <= (CNT_W+1)'(TOL)) begin
                note_hit = 1'b1;
                note_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/tone_period_meter.sv
// Measures rising-edge spacing of a square-wave tone and classifies it
// against the note table; flags silence after a period of no accepted edges.
module tone_period_meter
    import tone_pkg::*;
#(
    parameter int CNT_W      = 17,
    parameter int MIN_PERIOD = 1024,
    parameter int TIMEOUT    = 131071,
    parameter int TOL        = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [2:0]       note_idx,
    output logic             note_hit,
    output logic             silent
);

    logic             s1_q, s2_q, s3_q;
    logic             rise;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic [2:0]       note_idx_q, note_idx_d;
    logic             note_hit_q, note_hit_d;
    logic             silent_q, silent_d;
    logic             cls_hit;
    logic [2:0]       cls_idx;

    note_classifier #(
        .CNT_W (CNT_W),
        .TOL   (TOL)
    ) u_classifier (
        .period_in (cnt_q),
        .note_hit  (cls_hit),
        .note_idx  (cls_idx)
    );

    assign rise = s2_q & ~s3_q;

    // Two-flop synchronizer plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tone_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Next-state: arm on first edge, accept spaced edges, drop to silence on timeout.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        note_idx_d     = note_idx_q;
        note_hit_d     = note_hit_q;
        silent_d       = silent_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                // A too-close edge is a glitch: it falls through and counting continues.
                if (rise && (cnt_q >= CNT_W'(MIN_PERIOD))) begin
                    period_d       = cnt_q;
                    note_idx_d     = cls_idx;
                    note_hit_d     = cls_hit;
                    period_valid_d = 1'b1;
                    silent_d       = 1'b0;
                    cnt_d          = CNT_W'(1);
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d  = ST_IDLE;
                    silent_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            note_idx_q     <= 3'd0;
            note_hit_q     <= 1'b0;
            silent_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            note_idx_q     <= note_idx_d;
            note_hit_q     <= note_hit_d;
            silent_q       <= silent_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign note_idx     = note_idx_q;
    assign note_hit     = note_hit_q;
    assign silent       = silent_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: note matches, tolerance edges,
// glitch rejection, timeout to silence and asynchronous reset.
module tb_tone_period_meter;

    localparam int CNT_W = 17;
    localparam int TMO   = 60000;

    logic             clk = 1'b0;
    logic             rst;
    logic             tone_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [2:0]       note_idx;
    logic             note_hit;
    logic             silent;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    logic long_pulse = 1'b0;
    logic prev_pv = 1'b0;
    int pc;

    tone_period_meter #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (1024),
        .TIMEOUT    (TMO),
        .TOL        (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tone_in      (tone_in),
        .period       (period),
        .period_valid (period_valid),
        .note_idx     (note_idx),
        .note_hit     (note_hit),
        .silent       (silent)
    );

    always #5 clk = ~clk;

    // Pulse counter and width watch, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (period_valid) pulse_cnt++;
        if (period_valid && prev_pv) long_pulse = 1'b1;
        prev_pv = period_valid;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Arming edge: the meter must not report anything.
    task automatic arm(input string tag);
        pc = pulse_cnt;
        tone_in = 1'b1;
        repeat (4) @(negedge clk);
        chk(tag, pulse_cnt, pc);
    endtask

    // Completes a tone period whose rise was driven 4 cycles ago.
    task automatic finish_period(input int p);
        repeat (p / 2 - 4) @(negedge clk);
        tone_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    // Drive a rise and check the measurement pulse three cycles later.
    task automatic rise_check(input string tag, input int exp_p, input int exp_idx, input int exp_hit);
        pc = pulse_cnt;
        tone_in = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_pv"},     period_valid, 1);
        chk({tag, "_period"}, period, exp_p);
        chk({tag, "_idx"},    note_idx, exp_idx);
        chk({tag, "_hit"},    note_hit, exp_hit);
        chk({tag, "_silent"}, silent, 0);
        @(negedge clk);
        chk({tag, "_pv_off"}, period_valid, 0);
        chk({tag, "_npulse"}, pulse_cnt, pc + 1);
    endtask

    initial begin
        rst = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_silent", silent, 1);
        chk("rst_period", period, 0);
        chk("rst_hit", note_hit, 0);
        chk("rst_pv", period_valid, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_pulses", pulse_cnt, 0);
        chk("idle_silent", silent, 1);

        // A4 tone: arming edge, then one full period
        arm("a4_arm");
        chk("a4_arm_silent", silent, 1);
        finish_period(56818);
        rise_check("a4", 56818, 0, 1);

        // Just outside, then exactly at, the tolerance around C5
        finish_period(48078);
        rise_check("c5_out", 48078, 0, 0);
        finish_period(47522);
        rise_check("c5_edge", 47522, 2, 1);

        // 10-cycle glitch 500 cycles into a D5 period
        tone_in = 1'b0;
        repeat (496) @(negedge clk);
        pc = pulse_cnt;
        tone_in = 1'b1;
        repeat (10) @(negedge clk);
        tone_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_nopulse", pulse_cnt, pc);
        repeat (42565 - 515) @(negedge clk);
        rise_check("d5", 42565, 3, 1);

        // G5 then silence: silent rises exactly TMO cycles after the pulse
        finish_period(31888);
        rise_check("g5", 31888, 6, 1);
        tone_in = 1'b0;
        pc = pulse_cnt;
        repeat (TMO - 2) @(negedge clk);
        chk("tmo_early", silent, 0);
        @(negedge clk);
        chk("tmo_silent", silent, 1);
        chk("tmo_period", period, 31888);
        chk("tmo_idx", note_idx, 6);
        chk("tmo_nopulse", pulse_cnt, pc);

        // Restart after silence
        repeat (50) @(negedge clk);
        arm("re_arm");
        chk("re_arm_silent", silent, 1);
        finish_period(31888);
        rise_check("re_g5", 31888, 6, 1);

        // Asynchronous reset mid-measure, between clock edges
        tone_in = 1'b0;
        repeat (1000) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_silent", silent, 1);
        chk("arst_period", period, 0);
        chk("arst_idx", note_idx, 0);
        chk("arst_hit", note_hit, 0);
        chk("arst_pv", period_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        arm("post_rst_arm");

        // Shortest accepted period
        finish_period(1024);
        rise_check("min_p", 1024, 0, 0);

        // Edge one cycle short of the minimum is a glitch; next edge measures from the last accepted one
        repeat (200) @(negedge clk);
        tone_in = 1'b0;
        repeat (1023 - 204) @(negedge clk);
        pc = pulse_cnt;
        tone_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("short_nopulse", pulse_cnt, pc);
        tone_in = 1'b0;
        repeat (1500 - 1023 - 5) @(negedge clk);
        rise_check("after_short", 1500, 0, 0);

        chk("one_cycle_pulse", long_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
